// File: rtl/machine_sequencer_if.sv
// rtl/machine_sequencer_if.sv - byte-wide host command stream for the SAP sequencer
//
// Signals:
//   in_data   command or program byte from the host
//   in_valid  in_data holds a byte
//   in_ready  sequencer accepts the byte on a cycle with in_valid & in_ready
// Modports:
//   master  host side (drives in_data/in_valid)
//   slave   sequencer side (drives in_ready)
interface machine_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/machine_sequencer.sv
// rtl/machine_sequencer.sv - host-side load/run/step/reset sequencer for the SAP machine
//
// Ports:
//   clk                rising-edge clock
//   reset_n            asynchronous active-low reset
//   cmd                command stream (slave side of machine_sequencer_if)
//   halted             machine halted flag, combinational from the micro word
//   mach_clk_en        machine clock enable
//   mach_reset         machine synchronous reset, active-high
//   ctl_override       masks the micro-decoded bus strobes while loading
//   ext_en / ext_value external bus drive and the byte placed on the bus
//   ctl_write_mem_adr  forced memory address register write
//   ctl_write_mem      forced memory data write
//   state              FSM state encoding
//   cycle_count        saturating count of machine cycles since last RESET/LOAD
module machine_sequencer #(
  parameter int MEM_DEPTH = 16,
  parameter int ADDR_W    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  machine_sequencer_if.slave   cmd,
  input  logic                 halted,
  output logic                 mach_clk_en,
  output logic                 mach_reset,
  output logic                 ctl_override,
  output logic                 ext_en,
  output logic [7:0]           ext_value,
  output logic                 ctl_write_mem_adr,
  output logic                 ctl_write_mem,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_WAIT = 3'd1,
    S_LOAD_ADR  = 3'd2,
    S_LOAD_DAT  = 3'd3,
    S_RUN       = 3'd4,
    S_STEP      = 3'd5,
    S_MRESET    = 3'd6
  } state_t;

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_STEP  = 8'h03;
  localparam logic [7:0] CMD_RESET = 8'h04;
  localparam logic [7:0] CMD_STOP  = 8'h05;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              in_ready_q;
  logic              clk_en_q;
  logic              mach_reset_q;
  logic              override_q;
  logic              ext_en_q;
  logic              wr_adr_q;
  logic              wr_mem_q;
  logic [7:0]        ext_value_q;

  logic              hs;
  logic              free_run;
  logic              counting;

  assign hs = cmd.in_valid & in_ready_q;

  // In RUN and STEP the enable must drop in the very cycle halted rises, so
  // it bypasses the output register; every other enable source is registered.
  assign free_run    = (state_q == S_RUN) || (state_q == S_STEP);
  assign mach_clk_en = clk_en_q | (free_run & ~halted);

  assign counting = mach_clk_en & ~override_q & ~mach_reset_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;

    if (counting && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          case (cmd.in_data)
            CMD_LOAD: begin
              state_d = S_LOAD_WAIT;
              addr_d  = '0;
              count_d = '0;
            end
            CMD_RUN:   state_d = S_RUN;
            CMD_STEP:  state_d = S_STEP;
            CMD_RESET: state_d = S_MRESET;
            default:   state_d = S_IDLE;
          endcase
        end
      end

      // Every byte here is program data, even ones that look like commands.
      S_LOAD_WAIT: begin
        if (hs) begin
          data_d  = cmd.in_data;
          state_d = S_LOAD_ADR;
        end
      end

      S_LOAD_ADR: state_d = S_LOAD_DAT;

      S_LOAD_DAT: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_MRESET;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_LOAD_WAIT;
        end
      end

      // A STOP/RESET handshake wins over a simultaneous halt.
      S_RUN: begin
        if (hs && (cmd.in_data == CMD_STOP)) begin
          state_d = S_IDLE;
        end else if (hs && (cmd.in_data == CMD_RESET)) begin
          state_d = S_MRESET;
        end else if (halted) begin
          state_d = S_IDLE;
        end
      end

      S_STEP: state_d = S_IDLE;

      S_MRESET: begin
        count_d = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs are decoded from the
  // next state so they are valid for the whole cycle the state is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b1;
      clk_en_q     <= 1'b0;
      mach_reset_q <= 1'b0;
      override_q   <= 1'b0;
      ext_en_q     <= 1'b0;
      wr_adr_q     <= 1'b0;
      wr_mem_q     <= 1'b0;
      ext_value_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      count_q      <= count_d;
      in_ready_q   <= (state_d == S_IDLE) || (state_d == S_LOAD_WAIT) || (state_d == S_RUN);
      clk_en_q     <= (state_d == S_LOAD_ADR) || (state_d == S_LOAD_DAT) || (state_d == S_MRESET);
      mach_reset_q <= (state_d == S_MRESET);
      override_q   <= (state_d == S_LOAD_ADR) || (state_d == S_LOAD_DAT);
      ext_en_q     <= (state_d == S_LOAD_ADR) || (state_d == S_LOAD_DAT);
      wr_adr_q     <= (state_d == S_LOAD_ADR);
      wr_mem_q     <= (state_d == S_LOAD_DAT);
      if (state_d == S_LOAD_ADR) begin
        ext_value_q <= 8'(addr_d);
      end else if (state_d == S_LOAD_DAT) begin
        ext_value_q <= data_d;
      end else begin
        ext_value_q <= '0;
      end
    end
  end

  assign cmd.in_ready       = in_ready_q;
  assign mach_reset         = mach_reset_q;
  assign ctl_override       = override_q;
  assign ext_en             = ext_en_q;
  assign ext_value          = ext_value_q;
  assign ctl_write_mem_adr  = wr_adr_q;
  assign ctl_write_mem      = wr_mem_q;
  assign state              = state_q;
  assign cycle_count        = count_q;

endmodule

// File: doc/machine_sequencer.md
Name: machine_sequencer

Overview:
Host-side controller that sequences the SAP machine: loads program bytes into the 16-byte RAM over the shared bus, then starts, stops, single-steps and resets the machine. A byte-wide valid/ready command stream drives it. The sequencer owns the machine clock enable and synchronous reset. While it is driving memory writes, it overrides the micro-decoded bus strobes. The machine integration ANDs mach_clk_en into every machine flop enable and ORs the ctl_* strobes into the matching machine strobes. ctl_override masks all micro-decoded strobes.

Parameters:
MEM_DEPTH, 16, number of RAM bytes written by LOAD (addresses 0..MEM_DEPTH-1)
ADDR_W, 4, RAM address width; MEM_DEPTH <= 2**ADDR_W
CNT_W, 16, width of cycle_count

Ports:
clk  in  1  clock; everything sampled on rising edge
reset_n  in  1  asynchronous, active-low reset
in_data  in  8  command/data byte from host
in_valid  in  1  in_data valid
in_ready  out  1  byte accepted on a cycle with in_valid & in_ready
halted  in  1  machine halted flag (combinational from micro word)
mach_clk_en  out  1  machine clock enable
mach_reset  out  1  machine synchronous reset, active-high
ctl_override  out  1  masks micro-decoded strobes
ext_en  out  1  drives machine en_read_external
ext_value  out  8  value placed on bus when ext_en
ctl_write_mem_adr  out  1  forces memory address register write
ctl_write_mem  out  1  forces memory data write
state  out  3  FSM state: IDLE=0 LOAD_WAIT=1 LOAD_ADR=2 LOAD_DAT=3 RUN=4 STEP=5 MRESET=6
cycle_count  out  CNT_W  machine cycles executed since last RESET/LOAD

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset (reset_n=0): state=IDLE, addr=0, data reg=0, cycle_count=0. All outputs are 0 except in_ready=1, which follows the IDLE state.
- Reset mid-operation: aborts immediately. Partially loaded RAM is retained; RAM is not cleared.
- Commands are accepted in IDLE only, except STOP and RESET, which are also accepted in RUN:
  - 0x01 LOAD: addr<=0, cycle_count<=0, go to LOAD_WAIT.
  - 0x02 RUN: go to RUN.
  - 0x03 STEP: go to STEP.
  - 0x04 RESET: go to MRESET.
  - 0x05 STOP (RUN only): go to IDLE.
  - Any other byte, or a command not valid in the current state: consumed (in_ready=1) and ignored.
- in_ready=1 in IDLE, LOAD_WAIT and RUN; 0 in LOAD_ADR, LOAD_DAT, STEP and MRESET.
- LOAD_WAIT: on a handshake, capture in_data and go to LOAD_ADR. Holds indefinitely without in_valid. Command codes are not decoded here; every byte is data.
- LOAD_ADR (1 cycle): ext_en=1, ext_value={0,addr}, ctl_write_mem_adr=1, ctl_override=1, mach_clk_en=1. Go to LOAD_DAT.
- LOAD_DAT (1 cycle): ext_en=1, ext_value=data, ctl_write_mem=1, ctl_override=1, mach_clk_en=1.
  - If addr==MEM_DEPTH-1: addr<=0, go to MRESET.
  - Else: addr<=addr+1, go to LOAD_WAIT.
- Load throughput: minimum 3 cycles per byte. Addresses never wrap past MEM_DEPTH-1.
- MRESET (1 cycle): mach_reset=1, mach_clk_en=1, ctl_override=0, cycle_count<=0. Go to IDLE.
  - Reached from the RESET command or at the end of LOAD.
- RUN: mach_clk_en = ~halted (combinational), so the machine freezes on the halt micro-step.
  - If halted=1: go to IDLE.
  - A STOP or RESET handshake takes priority over halted.
  - RUN entered while halted=1: zero machine cycles, returns to IDLE the next cycle.
- STEP (1 cycle): mach_clk_en = ~halted. Go to IDLE.
- cycle_count: +1 on every cycle with mach_clk_en=1 & ctl_override=0 & mach_reset=0. Saturates at all-ones and does not wrap.
- ctl_override=0 and ext_en=0 in every state other than LOAD_ADR and LOAD_DAT.
- mach_clk_en=0 in IDLE and LOAD_WAIT.

Test Plan:
- Load with gaps: reset_n low then high; send 0x01, then bytes 0x10..0x1F with 0-3 idle cycles between -> 16 LOAD_ADR/LOAD_DAT pairs with ext_value 0x00..0x0F then 0x10..0x1F. One MRESET pulse follows, then state=0 and cycle_count=0.
- Run to halt: in IDLE send 0x02; halted rises after 40 machine cycles -> mach_clk_en low in the same cycle halted=1, state=0 next cycle, cycle_count=40.
- Step: in IDLE send 0x03 three times, halted=0 -> exactly three single-cycle mach_clk_en pulses, cycle_count=3, in_ready=0 during each STEP cycle.
- Stop/ignore in RUN: send 0x02, then 0x01 after 5 cycles, then 0x05 after 5 more -> 0x01 consumed and ignored, RUN continues. IDLE follows the STOP handshake; cycle_count=10.
- Abort load: send 0x01 and 3 data bytes, assert reset_n low during LOAD_DAT of byte 3 -> all outputs 0 immediately, state=0, in_ready=1 after release. RAM addresses 0-1 hold their bytes.
- RUN while halted: halted=1, send 0x02 -> mach_clk_en stays 0, state returns to 0 next cycle, cycle_count unchanged. Then send 0x04 -> one MRESET cycle, cycle_count=0.
